// File: rtl/panda_risc_v_rtr_ctrl.sv
// Retirement controller: normal/exception retirement of the ROB head, CSR bubble,
// debug halt and retired-instruction counting.
module panda_risc_v_rtr_ctrl #(
  parameter int RTR_CNT_WIDTH = 32,
  parameter bit CSR_BUBBLE_EN = 1'b1
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     rob_head_vld,
  input  logic                     rob_head_done,
  input  logic                     rob_head_excpt,
  input  logic                     rob_head_cancel,
  input  logic                     rob_head_is_csr_rw_inst,
  output logic                     rob_deq,
  output logic                     rob_rtr_bdcst_vld,
  output logic                     rob_rtr_bdcst_excpt_proc_grant,
  output logic                     excpt_proc_req,
  input  logic                     excpt_proc_ack,
  input  logic                     excpt_proc_done,
  output logic                     flush_req,
  input  logic                     dbg_halt_req,
  output logic                     dbg_halted,
  output logic                     rtr_cnt_en,
  output logic [RTR_CNT_WIDTH-1:0] rtr_cnt
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_EXCPT_REQ  = 2'd1;
  localparam logic [1:0] ST_EXCPT_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT       = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     bubble_q, bubble_d;
  logic [RTR_CNT_WIDTH-1:0] cnt_q;
  logic                     head_rdy;
  logic                     rtr_vld, rtr_grant, rtr_flush, cnt_inc;

  assign head_rdy = rob_head_vld & rob_head_done;

  always_comb begin
    state_d   = state_q;
    bubble_d  = 1'b0;
    rtr_vld   = 1'b0;
    rtr_grant = 1'b0;
    rtr_flush = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Halt wins over a ready head; the bubble cycle blocks everything else.
        if (dbg_halt_req) begin
          state_d = ST_HALT;
        end else if (!bubble_q && head_rdy) begin
          if (rob_head_cancel || !rob_head_excpt) begin
            rtr_vld  = 1'b1;
            cnt_inc  = ~rob_head_cancel;
            bubble_d = ~rob_head_cancel & rob_head_is_csr_rw_inst & CSR_BUBBLE_EN;
          end else begin
            state_d = ST_EXCPT_REQ;
          end
        end
      end
      ST_EXCPT_REQ: begin
        if (excpt_proc_ack) begin
          rtr_vld   = 1'b1;
          rtr_grant = 1'b1;
          rtr_flush = 1'b1;
          state_d   = ST_EXCPT_WAIT;
        end
      end
      ST_EXCPT_WAIT: begin
        if (excpt_proc_done) begin
          state_d = dbg_halt_req ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        if (!dbg_halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_RUN;
      bubble_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
      if (cnt_inc) begin
        cnt_q <= cnt_q + RTR_CNT_WIDTH'(1);
      end
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign rob_rtr_bdcst_vld              = rtr_vld & ~arst;
  assign rob_deq                        = rtr_vld & ~arst;
  assign rob_rtr_bdcst_excpt_proc_grant = rtr_grant & ~arst;
  assign flush_req                      = rtr_flush & ~arst;
  assign rtr_cnt_en                     = cnt_inc & ~arst;
  assign excpt_proc_req                 = (state_q == ST_EXCPT_REQ);
  assign dbg_halted                     = (state_q == ST_HALT);
  assign rtr_cnt                        = cnt_q;

endmodule

// File: tb/tb_panda_risc_v_rtr_ctrl.sv
// Scoreboard bench for panda_risc_v_rtr_ctrl (4-bit counter; bubble enabled and disabled).
module tb_panda_risc_v_rtr_ctrl;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic vld = 0, done = 0, excpt = 0, cancel = 0, csr = 0, ack = 0, pdone = 0, halt = 0;

  logic       deq, bdcst, grant, req, flush, halted, cnt_en;
  logic [3:0] cnt;
  logic       deq1, bdcst1, grant1, req1, flush1, halted1, cnt_en1;
  logic [3:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  panda_risc_v_rtr_ctrl #(.RTR_CNT_WIDTH(4), .CSR_BUBBLE_EN(1'b1)) dut (
    .aclk(clk), .arst(arst),
    .rob_head_vld(vld), .rob_head_done(done), .rob_head_excpt(excpt),
    .rob_head_cancel(cancel), .rob_head_is_csr_rw_inst(csr),
    .rob_deq(deq), .rob_rtr_bdcst_vld(bdcst), .rob_rtr_bdcst_excpt_proc_grant(grant),
    .excpt_proc_req(req), .excpt_proc_ack(ack), .excpt_proc_done(pdone),
    .flush_req(flush), .dbg_halt_req(halt), .dbg_halted(halted),
    .rtr_cnt_en(cnt_en), .rtr_cnt(cnt)
  );

  panda_risc_v_rtr_ctrl #(.RTR_CNT_WIDTH(4), .CSR_BUBBLE_EN(1'b0)) dut_nobub (
    .aclk(clk), .arst(arst),
    .rob_head_vld(vld), .rob_head_done(done), .rob_head_excpt(excpt),
    .rob_head_cancel(cancel), .rob_head_is_csr_rw_inst(csr),
    .rob_deq(deq1), .rob_rtr_bdcst_vld(bdcst1), .rob_rtr_bdcst_excpt_proc_grant(grant1),
    .excpt_proc_req(req1), .excpt_proc_ack(ack), .excpt_proc_done(pdone),
    .flush_req(flush1), .dbg_halt_req(halt), .dbg_halted(halted1),
    .rtr_cnt_en(cnt_en1), .rtr_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // in = {vld,done,excpt,cancel,csr,ack,pdone,halt}
  // e  = {bdcst,grant,flush,req,halted,cnt_en}; e1 = {check no-bubble dut, its bdcst}
  task automatic step(input logic [7:0] in, input logic [5:0] e, input logic [1:0] e1 = 2'b00);
    logic [11:0] ent;
    {vld, done, excpt, cancel, csr, ack, pdone, halt} = in;
    exp_q.push_back({e1, e, exp_cnt});
    @(negedge clk);
    ent = exp_q.pop_front();
    $display("step in=%b bdcst=%b grant=%b flush=%b req=%b halted=%b cnt_en=%b cnt=%0d",
             in, bdcst, grant, flush, req, halted, cnt_en, cnt);
    check("bdcst_vld", bdcst,  ent[9]);
    check("rob_deq",   deq,    ent[9]);
    check("grant",     grant,  ent[8]);
    check("flush_req", flush,  ent[7]);
    check("excpt_req", req,    ent[6]);
    check("dbg_halted", halted, ent[5]);
    check("rtr_cnt_en", cnt_en, ent[4]);
    check("rtr_cnt",   cnt,    ent[3:0]);
    if (ent[11]) check("nobub_bdcst", bdcst1, ent[10]);
    if (e[0]) exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: combinational outputs stay low even with a ready head
    step(8'b1100_0000, 6'b000000);
    arst = 1'b0;

    // Three back-to-back plain retirements
    repeat (3) step(8'b1100_0000, 6'b100001);
    step(8'b0000_0000, 6'b000000);

    // CSR retire -> bubble cycle -> retire; no-bubble variant retires every cycle
    step(8'b1100_1000, 6'b100001, 2'b11);
    step(8'b1100_0000, 6'b000000, 2'b11);
    step(8'b1100_0000, 6'b100001, 2'b11);
    step(8'b0000_0000, 6'b000000);
    check("nobub_cnt", cnt1, 4'd6);

    // Exception: req 2 cycles, ack (with simultaneous done ignored), wait, done with halt pending
    step(8'b1110_0000, 6'b000000);
    step(8'b1110_0000, 6'b000100);
    step(8'b1110_0110, 6'b111100);
    step(8'b1100_0001, 6'b000000);
    step(8'b1100_0001, 6'b000000);
    step(8'b1100_0011, 6'b000000);
    step(8'b1100_0000, 6'b000010);
    step(8'b1100_0000, 6'b100001);
    step(8'b0000_0100, 6'b000000);

    // Cancelled head carrying an exception retires normally, uncounted
    step(8'b1111_0000, 6'b100000);
    step(8'b0000_0000, 6'b000000);

    // Debug halt over a ready head, then release
    step(8'b1100_0001, 6'b000000);
    step(8'b1100_0001, 6'b000010);
    step(8'b1100_0000, 6'b000010);
    step(8'b1100_0000, 6'b100001);

    // Counter wrap at all-ones
    while (exp_cnt != 4'd15) step(8'b1100_0000, 6'b100001);
    step(8'b0000_0000, 6'b000000);
    step(8'b1100_0000, 6'b100001);
    step(8'b0000_0000, 6'b000000);
    step(8'b1100_0000, 6'b100001);

    // Reset asserted while waiting for ack returns to RUN at once
    step(8'b1110_0000, 6'b000000);
    step(8'b1110_0000, 6'b000100);
    arst = 1'b1;
    exp_cnt = 4'd0;
    step(8'b1110_0100, 6'b000000);
    arst = 1'b0;
    step(8'b1100_0000, 6'b100001);
    step(8'b0000_0000, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
